// File: rtl/mat_mul_pkg.sv
// Shared types and helpers for the streaming matrix-multiply engine.
// The MAT_MUL_STREAM_SAT_EN build uses sat_clamp on stored results.
package mat_mul_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_OUTPUT = 2'd2
  } state_e;

  // Working width for the clamp; wide enough for any supported accumulator.
  localparam int unsigned SAT_W = 128;

  function automatic int unsigned dim_of(input int unsigned dim_log);
    return 32'd1 << dim_log;
  endfunction

  function automatic int unsigned size_of(input int unsigned dim_log);
    return 32'd1 << (2 * dim_log);
  endfunction

  function automatic int unsigned size_log_of(input int unsigned dim_log);
    return 2 * dim_log;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_clamp(input logic signed [SAT_W-1:0] v,
                                                        input int unsigned dw);
    logic signed [SAT_W-1:0] one;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    one = SAT_W'(1);
    hi  = (one <<< (dw - 1)) - one;
    lo  = -hi - one;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/mat_mul_stream_mac.sv
// Registered signed multiply-accumulate; clear restarts the sum with the current product.
module mac_unit
  import mat_mul_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ACC_WIDTH  = 2*DATA_WIDTH + 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid,
  input  logic                         clear,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [ACC_WIDTH-1:0]  acc
);

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    prod_ext;
  logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;

  always_comb begin
    prod     = (2*DATA_WIDTH)'(a) * (2*DATA_WIDTH)'(b);
    prod_ext = ACC_WIDTH'(prod);
    acc_d    = acc_q;
    if (valid) acc_d = clear ? prod_ext : acc_q + prod_ext;
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/mat_mul_stream.sv
// AXI-Stream matrix-multiply engine: load A/B, compute R = A*B, stream R out.
// Define MAT_MUL_STREAM_SAT_EN to clamp stored results instead of wrapping.
module mat_mul_stream
  import mat_mul_pkg::*;
#(
  parameter int unsigned DIM_LOG    = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ACC_WIDTH  = 2*DATA_WIDTH + DIM_LOG
) (
  input  logic                    s00_axi_aclk,
  input  logic                    s00_axi_areset,
  input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic                    s00_axis_tvalid,
  input  logic                    s00_axis_tlast,
  output logic                    s00_axis_tready,
  output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                    m00_axis_tvalid,
  output logic                    m00_axis_tlast,
  input  logic                    m00_axis_tready,
  input  logic                    sel,
  input  logic                    start,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned DIM      = dim_of(DIM_LOG);
  localparam int unsigned SIZE     = size_of(DIM_LOG);
  localparam int unsigned SIZE_LOG = size_log_of(DIM_LOG);
  localparam int unsigned CNT_W    = SIZE_LOG + DIM_LOG + 1;
  localparam logic [CNT_W-1:0]    ISSUE_END = CNT_W'(SIZE*DIM);
  localparam logic [CNT_W-1:0]    CALC_LAST = CNT_W'(SIZE*DIM + 1);
  localparam logic [SIZE_LOG-1:0] ADDR_LAST = SIZE_LOG'(SIZE - 1);

  logic clk, rst;
  assign clk = s00_axi_aclk;
  assign rst = s00_axi_areset;

  state_e state_q, state_d;
  logic tready_q, tready_d, tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic busy_q, busy_d, done_q, done_d;
  logic in_frame_q, in_frame_d, frame_sel_q, frame_sel_d, pref_q, pref_d;
  logic [SIZE_LOG-1:0] ld_addr_q, ld_addr_d, out_idx_q, out_idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic p1_v_q, p1_v_d, p1_clr_q, p1_clr_d, p1_last_q, p1_last_d, p2_we_q, p2_we_d;
  logic [SIZE_LOG-1:0] p1_addr_q, p1_addr_d, p2_addr_q, p2_addr_d;

  logic [DIM_LOG-1:0]  idx_r, idx_c, idx_k;
  logic [SIZE_LOG-1:0] addr_a, addr_b, addr_r, out_next;
  logic we_a, we_b, we_r, rd_r_en, s_hs, o_hs, eff_sel, issue;
  logic [DATA_WIDTH-1:0] mem_a [SIZE];
  logic [DATA_WIDTH-1:0] mem_b [SIZE];
  logic [DATA_WIDTH-1:0] mem_r [SIZE];
  logic [DATA_WIDTH-1:0] rd_a_q, rd_b_q, rd_r_q, r_wdata;
  logic signed [ACC_WIDTH-1:0] acc;

  // cnt = r*SIZE + c*DIM + k, so the loop indices are plain bit fields.
  assign idx_k = cnt_q[DIM_LOG-1:0];
  assign idx_c = cnt_q[2*DIM_LOG-1:DIM_LOG];
  assign idx_r = cnt_q[3*DIM_LOG-1:2*DIM_LOG];

  assign eff_sel  = in_frame_q ? frame_sel_q : sel;
  assign s_hs     = (state_q == S_IDLE) && s00_axis_tvalid && tready_q;
  assign o_hs     = tvalid_q && m00_axis_tready;
  assign issue    = (state_q == S_CALC) && (cnt_q < ISSUE_END);
  assign out_next = out_idx_q + SIZE_LOG'(1);
  assign we_a     = s_hs && !eff_sel;
  assign we_b     = s_hs && eff_sel;
  assign we_r     = p2_we_q && (state_q == S_CALC);
  assign rd_r_en  = (state_q == S_OUTPUT);
  assign addr_a   = (state_q == S_IDLE) ? ld_addr_q : {idx_r, idx_k};
  assign addr_b   = (state_q == S_IDLE) ? ld_addr_q : {idx_k, idx_c};

  always_comb begin
    state_d     = state_q;
    tready_d    = tready_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    in_frame_d  = in_frame_q;
    frame_sel_d = frame_sel_q;
    pref_d      = pref_q;
    ld_addr_d   = ld_addr_q;
    out_idx_d   = out_idx_q;
    cnt_d       = cnt_q;
    addr_r      = (state_q == S_CALC) ? p2_addr_q : out_idx_q;

    // Read-side pipeline: addresses issue now, data and MAC follow one cycle apart.
    p1_v_d    = issue;
    p1_clr_d  = (idx_k == '0);
    p1_last_d = (idx_k == '1);
    p1_addr_d = {idx_r, idx_c};
    p2_we_d   = p1_v_q && p1_last_q;
    p2_addr_d = p1_addr_q;

    case (state_q)
      S_IDLE: begin
        tready_d = 1'b1;
        tvalid_d = 1'b0;
        if (s_hs) begin
          if (s00_axis_tlast) begin
            ld_addr_d  = '0;
            in_frame_d = 1'b0;
          end else begin
            ld_addr_d   = ld_addr_q + SIZE_LOG'(1);
            in_frame_d  = 1'b1;
            frame_sel_d = eff_sel;
          end
        end
        if (start && (ld_addr_q == '0)) begin
          state_d    = S_CALC;
          tready_d   = 1'b0;
          busy_d     = 1'b1;
          cnt_d      = '0;
          in_frame_d = 1'b0;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CALC_LAST) begin
          state_d   = S_OUTPUT;
          out_idx_d = '0;
          pref_d    = 1'b0;
        end
      end
      S_OUTPUT: begin
        // First cycle only primes the read register so tvalid rises with element 0.
        if (!pref_q) begin
          pref_d   = 1'b1;
          tvalid_d = 1'b1;
          tlast_d  = (out_idx_q == ADDR_LAST);
        end else if (o_hs) begin
          if (out_idx_q == ADDR_LAST) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            tready_d = 1'b1;
            state_d  = S_IDLE;
          end else begin
            out_idx_d = out_next;
            addr_r    = out_next;
            tlast_d   = (out_next == ADDR_LAST);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tready_q    <= 1'b0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_frame_q  <= 1'b0;
      frame_sel_q <= 1'b0;
      pref_q      <= 1'b0;
      ld_addr_q   <= '0;
      out_idx_q   <= '0;
      cnt_q       <= '0;
      p1_v_q      <= 1'b0;
      p1_clr_q    <= 1'b0;
      p1_last_q   <= 1'b0;
      p1_addr_q   <= '0;
      p2_we_q     <= 1'b0;
      p2_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      tready_q    <= tready_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      in_frame_q  <= in_frame_d;
      frame_sel_q <= frame_sel_d;
      pref_q      <= pref_d;
      ld_addr_q   <= ld_addr_d;
      out_idx_q   <= out_idx_d;
      cnt_q       <= cnt_d;
      p1_v_q      <= p1_v_d;
      p1_clr_q    <= p1_clr_d;
      p1_last_q   <= p1_last_d;
      p1_addr_q   <= p1_addr_d;
      p2_we_q     <= p2_we_d;
      p2_addr_q   <= p2_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we_a) mem_a[addr_a] <= s00_axis_tdata;
    rd_a_q <= mem_a[addr_a];
  end

  always_ff @(posedge clk) begin
    if (we_b) mem_b[addr_b] <= s00_axis_tdata;
    rd_b_q <= mem_b[addr_b];
  end

  always_ff @(posedge clk) begin
    if (we_r) mem_r[addr_r] <= r_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)          rd_r_q <= '0;
    else if (rd_r_en) rd_r_q <= mem_r[addr_r];
  end

  mac_unit #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk  (clk),
    .rst  (rst),
    .valid(p1_v_q),
    .clear(p1_clr_q),
    .a    (signed'(rd_a_q)),
    .b    (signed'(rd_b_q)),
    .acc  (acc)
  );

`ifdef MAT_MUL_STREAM_SAT_EN
  assign r_wdata = DATA_WIDTH'(sat_clamp(SAT_W'(acc), DATA_WIDTH));
`else
  assign r_wdata = DATA_WIDTH'(acc);
`endif

  assign s00_axis_tready = tready_q;
  assign m00_axis_tdata  = rd_r_q;
  assign m00_axis_tstrb  = '1;
  assign m00_axis_tvalid = tvalid_q;
  assign m00_axis_tlast  = tlast_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule
